ir_assembler: RTL

Parametrised instruction register that assembles one INST_W-bit instruction from successive BUS_W-bit beats on the fetch bus. It presents the decoded opcode and address fields to the controller through a valid/ready handshake. It sits between memory/fetch datapath and the control FSM, and succeeds the fixed 8-to-16-bit two-state instruction register. Over that block it adds configurable widths, backpressure, flush, and optional double buffering.

---
 rtl/ir_pkg.sv | 26 ++
 rtl/ir_beat_counter.sv | 46 ++++
 rtl/ir_assembler.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ir_pkg.sv
// rtl/ir_pkg.sv - shared sizing helpers for the instruction register assembler
// Purpose: derives beat count and beat-counter width from the bus/instruction
//          widths, and provides the configuration legality check used at
//          elaboration by ir_assembler.
// Contents: ir_beats(), ir_cnt_w(), ir_cfg_ok()
package ir_pkg;

   // Number of fetch beats that make up one instruction.
   function automatic int ir_beats(input int inst_w, input int bus_w);
      return inst_w / bus_w;
   endfunction

   // Beat counter width: clog2(beats), but never narrower than one bit so a
   // single-beat configuration still has a legal counter register.
   function automatic int ir_cnt_w(input int beats);
      return (beats <= 1) ? 1 : $clog2(beats);
   endfunction

   // Legal when the instruction is a whole number of beats (at least one) and
   // the opcode leaves at least one address bit.
   function automatic bit ir_cfg_ok(input int inst_w, input int bus_w, input int op_w);
      return (bus_w >= 1) && (inst_w >= bus_w) && ((inst_w % bus_w) == 0) &&
             (op_w >= 1) && (op_w < inst_w);
   endfunction

endpackage

// File: rtl/ir_beat_counter.sv
// rtl/ir_beat_counter.sv - modulo-BEATS beat counter for the fetch sequencer
// Purpose: counts accepted beats 0..BEATS-1, wrapping to 0 after the last.
//          Clear has priority over increment.
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   inc_i        advance one beat
//   clr_i        return to beat 0
//   cnt_o        current beat index
//   last_o       current beat is the final beat of an instruction
module ir_beat_counter #(
   parameter int BEATS = 2,
   parameter int CNT_W = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             last_o
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign cnt_o  = cnt_q;
   assign last_o = (cnt_q == LAST_CNT);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = last_o ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ir_assembler.sv
// rtl/ir_assembler.sv - instruction register assembling INST_W-bit words from BUS_W-bit beats
// Purpose: collects big-endian fetch beats into one instruction and presents
//          opcode/address fields to the controller with a valid/ready handshake.
// Build option: IR_SHADOW_EN - separate assembly register so the next fetch
//          overlaps the hold of the current instruction; undefined gives a
//          single in-place register that stalls fetch while an instruction is held.
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   en                    fetch enable; low discards a partial instruction
//   flush                 synchronous clear of partial and held instruction
//   in_valid/in_data      fetch beat offered
//   in_ready              beat accepted when in_valid && in_ready
//   inst_valid/inst_ready held instruction handshake
//   operation             instruction opcode field (MSBs)
//   ir_addr               instruction address field (remaining LSBs)
//   busy                  partial instruction in progress
module ir_assembler
   import ir_pkg::*;
#(
   parameter int BUS_W  = 8,
   parameter int INST_W = 16,
   parameter int OP_W   = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic                   flush,
   input  logic                   in_valid,
   input  logic [BUS_W-1:0]       in_data,
   output logic                   in_ready,
   output logic                   inst_valid,
   input  logic                   inst_ready,
   output logic [OP_W-1:0]        operation,
   output logic [INST_W-OP_W-1:0] ir_addr,
   output logic                   busy
);

   localparam int BEATS  = ir_beats(INST_W, BUS_W);
   localparam int CNT_W  = ir_cnt_w(BEATS);
   localparam int ADDR_W = INST_W - OP_W;

   if (!ir_cfg_ok(INST_W, BUS_W, OP_W)) begin : g_cfg_err
      $error("ir_assembler: INST_W must be a multiple of BUS_W and OP_W < INST_W");
   end

   logic [CNT_W-1:0]  cnt;
   logic              cnt_last;
   logic              accept;
   logic [INST_W-1:0] ir_q, ir_d;
   logic              inst_valid_q, inst_valid_d;

   assign accept = in_valid && in_ready;

   // A dropped enable or a flush restarts assembly at beat 0.
   ir_beat_counter #(
      .BEATS (BEATS),
      .CNT_W (CNT_W)
   ) u_beat_counter (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc_i  (accept),
      .clr_i  (!en || flush),
      .cnt_o  (cnt),
      .last_o (cnt_last)
   );

`ifdef IR_SHADOW_EN
   logic [INST_W-1:0] asm_q, asm_d;

   // Early beats always land in the assembly register; only the completing
   // beat has to wait for the output register to be free (or freed this cycle).
   assign in_ready = rst_n && en && !flush && (!cnt_last || !inst_valid_q || inst_ready);

   always_comb begin
      asm_d = asm_q;
      ir_d  = ir_q;
      if (accept) begin
         if (cnt_last) begin
            ir_d              = asm_q;
            ir_d[BUS_W-1:0]   = in_data;
         end else begin
            for (int b = 0; b < BEATS; b++) begin
               if (cnt == CNT_W'(b)) begin
                  asm_d[(BEATS-1-b)*BUS_W +: BUS_W] = in_data;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         asm_q <= '0;
      end else begin
         asm_q <= asm_d;
      end
   end
`else
   // Beats overwrite the output register in place, so nothing may be
   // accepted while an instruction is still being held for the consumer.
   assign in_ready = rst_n && en && !flush && !inst_valid_q;

   always_comb begin
      ir_d = ir_q;
      if (accept) begin
         for (int b = 0; b < BEATS; b++) begin
            if (cnt == CNT_W'(b)) begin
               ir_d[(BEATS-1-b)*BUS_W +: BUS_W] = in_data;
            end
         end
      end
   end
`endif

   // Completion outranks a same-cycle consume so an overlapped fetch is not lost.
   always_comb begin
      inst_valid_d = inst_valid_q;
      if (flush) begin
         inst_valid_d = 1'b0;
      end else if (accept && cnt_last) begin
         inst_valid_d = 1'b1;
      end else if (inst_ready) begin
         inst_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir_q         <= '0;
         inst_valid_q <= 1'b0;
      end else begin
         ir_q         <= ir_d;
         inst_valid_q <= inst_valid_d;
      end
   end

   assign inst_valid = inst_valid_q;
   assign operation  = ir_q[INST_W-1 -: OP_W];
   assign ir_addr    = ir_q[ADDR_W-1:0];
   assign busy       = |cnt;

endmodule
